mac_mii_rx: RTL and testbench

Receive-side counterpart to the MAC/MII frame generator. Consumes the 64-bit, 8-lane MII data/control stream and locates frame start, preamble/SFD and terminate. Extracts the destination address, source address and EtherType, and streams the payload bytes with per-byte strobes with the FCS stripped. At end of frame it reports payload length, CRC status, length status and control-character status. It sits between the MII/PCS receive path and the verification scoreboard, closing the loop with the generator.

---
 rtl/mii_rx_pkg.sv | 49 ++++
 rtl/crc32_d64.sv | 31 +++
 rtl/mac_mii_rx.sv | 229 ++++++++++++++++++++++
 tb/tb_mac_mii_rx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mii_rx_pkg.sv
`default_nettype none
// ============================================================
// mii_rx_pkg: shared constants, state type and helpers for mac_mii_rx
// Revision: 1.0
// ============================================================
package mii_rx_pkg;

  localparam logic [7:0] CTRL_IDLE  = 8'h07;
  localparam logic [7:0] CTRL_START = 8'hFB;
  localparam logic [7:0] CTRL_TERM  = 8'hFD;
  localparam logic [7:0] PREAMBLE   = 8'h55;
  localparam logic [7:0] SFD        = 8'hD5;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_DROP  = 3'd3,
    ST_FLUSH = 3'd4
  } rx_state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] m);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + {3'd0, m[i]};
    return s;
  endfunction

  // Keep only the n lowest-lane set bits of m.
  function automatic logic [7:0] keep_low(input logic [7:0] m, input logic [3:0] n);
    logic [7:0] r;
    logic [3:0] k;
    r = '0;
    k = '0;
    for (int i = 0; i < 8; i++) begin
      if (m[i] && (k < n)) begin
        r[i] = 1'b1;
        k    = k + 4'd1;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc32_d64.sv
`default_nettype none
// ============================================================
// crc32_d64: reflected CRC-32 update over up to 8 enabled bytes, lane 0 first
// Revision: 1.0
// ============================================================
module crc32_d64
  import mii_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [63:0] data,
  input  logic [7:0]  byte_en,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (byte_en[i]) begin
        c = c ^ {24'd0, data[8*i +: 8]};
        for (int b = 0; b < 8; b++) begin
          c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
      end
    end
    crc_out = c;
  end

endmodule
`default_nettype wire

// File: rtl/mac_mii_rx.sv
`default_nettype none
// ============================================================
// mac_mii_rx: 64-bit MII receive deframer; header extract, FCS strip and check
// Revision: 1.0
// ============================================================
module mac_mii_rx
  import mii_rx_pkg::*;
#(
  parameter int unsigned PAYLOAD_MAX_SIZE = 1500,
  parameter int unsigned PAYLOAD_MIN_SIZE = 46
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic [63:0] i_mii_rx_d,
  input  logic [7:0]  i_mii_rx_c,
  output logic [47:0] o_dest_address,
  output logic [47:0] o_src_address,
  output logic [15:0] o_eth_type,
  output logic        o_hdr_valid,
  output logic [63:0] o_payload_data,
  output logic [7:0]  o_payload_valid,
  output logic        o_frame_done,
  output logic [15:0] o_payload_length,
  output logic        o_crc_err,
  output logic        o_len_err,
  output logic        o_ctrl_err
);

  rx_state_e   state, state_n;
  logic        first, first_n;
  logic [63:0] hold_d, hold_d_n;
  logic [7:0]  hold_m, hold_m_n;
  logic [31:0] crc, crc_n, crc_upd;
  logic [47:0] dest, dest_n;
  logic [15:0] src_hi, src_hi_n;
  logic [47:0] dest_out_n, src_out_n;
  logic [15:0] type_n, count_n;
  logic        hdr_valid_n, done_n, len_err_n, crc_err_n, ctrl_err_n;
  logic [7:0]  pay_valid_n;

  logic [7:0]  term_lanes, before_m, after_m, fcs_h, tail_m, emit_m;
  logic [2:0]  term_pos;
  logic        term_hit, start_ok, ctrl_bad, over;
  logic [31:0] count_ext, room, sum;

  assign start_ok = (i_mii_rx_c == 8'h01) && (i_mii_rx_d[7:0] == CTRL_START) &&
                    (i_mii_rx_d[55:8] == {6{PREAMBLE}}) && (i_mii_rx_d[63:56] == SFD);

  // Lane decode: first terminate, lanes before it, lanes after it, stray control.
  always_comb begin
    term_lanes = '0;
    before_m   = '0;
    after_m    = '0;
    term_pos   = '0;
    ctrl_bad   = 1'b0;
    for (int i = 0; i < 8; i++)
      term_lanes[i] = i_mii_rx_c[i] && (i_mii_rx_d[8*i +: 8] == CTRL_TERM);
    for (int i = 7; i >= 0; i--)
      if (term_lanes[i]) term_pos = 3'(i);
    term_hit = |term_lanes;
    for (int i = 0; i < 8; i++) begin
      before_m[i] = !term_hit || (3'(i) < term_pos);
      after_m[i]  = term_hit && (3'(i) > term_pos);
      if (before_m[i] && i_mii_rx_c[i]) ctrl_bad = 1'b1;
      if (after_m[i] && !(i_mii_rx_c[i] && (i_mii_rx_d[8*i +: 8] == CTRL_IDLE)))
        ctrl_bad = 1'b1;
    end
    fcs_h  = (term_hit && (term_pos < 3'd4)) ? (8'hF0 << term_pos) : 8'h00;
    tail_m = (term_pos >= 3'd4) ? ((8'd1 << (term_pos - 3'd4)) - 8'd1) : 8'd0;
  end

  crc32_d64 u_crc (
    .crc_in  (crc),
    .data    (i_mii_rx_d),
    .byte_en (before_m),
    .crc_out (crc_upd)
  );

  always_comb begin
    state_n     = state;
    first_n     = first;
    hold_d_n    = hold_d;
    hold_m_n    = hold_m;
    crc_n       = crc;
    dest_n      = dest;
    src_hi_n    = src_hi;
    dest_out_n  = o_dest_address;
    src_out_n   = o_src_address;
    type_n      = o_eth_type;
    len_err_n   = o_len_err;
    crc_err_n   = o_crc_err;
    ctrl_err_n  = o_ctrl_err;
    hdr_valid_n = 1'b0;
    done_n      = 1'b0;
    emit_m      = '0;
    over        = 1'b0;

    if (state == ST_DATA)       emit_m = hold_m & ~fcs_h;
    else if (state == ST_FLUSH) emit_m = hold_m;

    // Clip emission so the running count never passes the maximum.
    count_ext = {16'd0, o_payload_length};
    room      = (count_ext >= PAYLOAD_MAX_SIZE) ? 32'd0 : (PAYLOAD_MAX_SIZE - count_ext);
    if ({28'd0, popcount8(emit_m)} > room) begin
      over   = 1'b1;
      emit_m = keep_low(emit_m, room[3:0]);
    end
    sum         = count_ext + {28'd0, popcount8(emit_m)};
    count_n     = (sum > 32'h0000_FFFF) ? 16'hFFFF : sum[15:0];
    pay_valid_n = emit_m;
    if (over) len_err_n = 1'b1;

    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          state_n    = ST_HDR;
          crc_n      = CRC_INIT;
          hold_m_n   = '0;
          count_n    = '0;
          len_err_n  = 1'b0;
          crc_err_n  = 1'b0;
          ctrl_err_n = 1'b0;
        end
      end
      ST_HDR: begin
        crc_n = crc_upd;
        if (ctrl_bad) ctrl_err_n = 1'b1;
        if (term_hit) begin
          len_err_n = 1'b1;
          hold_m_n  = '0;
          state_n   = ST_FLUSH;
        end else begin
          dest_n   = {i_mii_rx_d[7:0], i_mii_rx_d[15:8], i_mii_rx_d[23:16],
                      i_mii_rx_d[31:24], i_mii_rx_d[39:32], i_mii_rx_d[47:40]};
          src_hi_n = {i_mii_rx_d[55:48], i_mii_rx_d[63:56]};
          first_n  = 1'b1;
          state_n  = ST_DATA;
        end
      end
      ST_DATA: begin
        crc_n    = crc_upd;
        hold_d_n = i_mii_rx_d;
        first_n  = 1'b0;
        if (ctrl_bad) ctrl_err_n = 1'b1;
        if (first) begin
          if (term_hit) begin
            len_err_n = 1'b1;
            hold_m_n  = '0;
            state_n   = ST_FLUSH;
          end else begin
            dest_out_n  = dest;
            src_out_n   = {src_hi, i_mii_rx_d[7:0], i_mii_rx_d[15:8],
                           i_mii_rx_d[23:16], i_mii_rx_d[31:24]};
            type_n      = {i_mii_rx_d[39:32], i_mii_rx_d[47:40]};
            hdr_valid_n = 1'b1;
            hold_m_n    = 8'hC0;
          end
        end else if (term_hit) begin
          hold_m_n = tail_m;
          state_n  = ST_FLUSH;
        end else begin
          hold_m_n = 8'hFF;
        end
        if (over) begin
          hold_m_n = '0;
          state_n  = term_hit ? ST_FLUSH : ST_DROP;
        end
      end
      ST_DROP: begin
        crc_n    = crc_upd;
        hold_m_n = '0;
        if (ctrl_bad) ctrl_err_n = 1'b1;
        if (term_hit) state_n = ST_FLUSH;
      end
      ST_FLUSH: begin
        done_n    = 1'b1;
        crc_err_n = (crc != CRC_RESIDUE);
        if ({16'd0, count_n} < PAYLOAD_MIN_SIZE) len_err_n = 1'b1;
        hold_m_n  = '0;
        state_n   = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state            <= ST_IDLE;
      first            <= 1'b0;
      hold_d           <= '0;
      hold_m           <= '0;
      crc              <= CRC_INIT;
      dest             <= '0;
      src_hi           <= '0;
      o_dest_address   <= '0;
      o_src_address    <= '0;
      o_eth_type       <= '0;
      o_hdr_valid      <= 1'b0;
      o_payload_data   <= '0;
      o_payload_valid  <= '0;
      o_frame_done     <= 1'b0;
      o_payload_length <= '0;
      o_crc_err        <= 1'b0;
      o_len_err        <= 1'b0;
      o_ctrl_err       <= 1'b0;
    end else begin
      state            <= state_n;
      first            <= first_n;
      hold_d           <= hold_d_n;
      hold_m           <= hold_m_n;
      crc              <= crc_n;
      dest             <= dest_n;
      src_hi           <= src_hi_n;
      o_dest_address   <= dest_out_n;
      o_src_address    <= src_out_n;
      o_eth_type       <= type_n;
      o_hdr_valid      <= hdr_valid_n;
      o_payload_data   <= hold_d;
      o_payload_valid  <= pay_valid_n;
      o_frame_done     <= done_n;
      o_payload_length <= count_n;
      o_crc_err        <= crc_err_n;
      o_len_err        <= len_err_n;
      o_ctrl_err       <= ctrl_err_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_mii_rx.sv
`default_nettype none
// ============================================================
// tb_mac_mii_rx: scoreboard bench for mac_mii_rx
// Revision: 1.0
// ============================================================
module tb_mac_mii_rx;

  localparam logic [63:0] START_W  = 64'hD555_5555_5555_55FB;
  localparam logic [63:0] BADST_W  = 64'hD555_5555_5455_55FB;
  localparam logic [63:0] IDLE_W   = 64'h0707_0707_0707_0707;
  localparam logic [47:0] DST      = 48'h0A0B_0C0D_0E0F;
  localparam logic [47:0] SRC      = 48'h1122_3344_5566;
  localparam logic [15:0] ETYPE    = 16'h0800;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] rx_d;
  logic [7:0]  rx_c;
  logic [47:0] dest_address, src_address;
  logic [15:0] eth_type, payload_length;
  logic        hdr_valid, frame_done, crc_err, len_err, ctrl_err;
  logic [63:0] payload_data;
  logic [7:0]  payload_valid;

  always #5 clk = ~clk;

  mac_mii_rx #(.PAYLOAD_MAX_SIZE(1500), .PAYLOAD_MIN_SIZE(46)) dut (
    .clk              (clk),
    .i_rst_n          (rst_n),
    .i_mii_rx_d       (rx_d),
    .i_mii_rx_c       (rx_c),
    .o_dest_address   (dest_address),
    .o_src_address    (src_address),
    .o_eth_type       (eth_type),
    .o_hdr_valid      (hdr_valid),
    .o_payload_data   (payload_data),
    .o_payload_valid  (payload_valid),
    .o_frame_done     (frame_done),
    .o_payload_length (payload_length),
    .o_crc_err        (crc_err),
    .o_len_err        (len_err),
    .o_ctrl_err       (ctrl_err)
  );

  // chk: bit3 length, bit2 crc_err, bit1 len_err, bit0 ctrl_err
  typedef struct packed {
    logic [15:0] len;
    logic        ce;
    logic        le;
    logic        ke;
    logic [3:0]  chk;
  } res_t;

  int          checks = 0;
  int          failures = 0;
  int          hdr_seen = 0;
  int          done_seen = 0;
  logic [7:0]  tx_b[$];
  logic        tx_k[$];
  logic [8:0]  exp_bytes[$];
  logic [111:0] exp_hdr[$];
  res_t        exp_res[$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] all_outputs();
    return {51'd0, dest_address, src_address, eth_type, hdr_valid, payload_data,
            payload_valid, frame_done, payload_length, crc_err, len_err, ctrl_err};
  endfunction

  task automatic monitor();
    logic [111:0] eh;
    logic [8:0]   eb;
    res_t         r;
    if (hdr_valid) begin
      hdr_seen++;
      chk("hdr_expected", exp_hdr.size() > 0, 1);
      if (exp_hdr.size() > 0) begin
        eh = exp_hdr.pop_front();
        chk("header", {dest_address, src_address, eth_type}, eh);
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (payload_valid[i]) begin
        chk("byte_expected", exp_bytes.size() > 0, 1);
        if (exp_bytes.size() > 0) begin
          eb = exp_bytes.pop_front();
          if (!eb[8]) chk("payload_byte", payload_data[8*i +: 8], eb[7:0]);
        end
      end
    end
    if (frame_done) begin
      done_seen++;
      chk("done_expected", exp_res.size() > 0, 1);
      if (exp_res.size() > 0) begin
        r = exp_res.pop_front();
        chk("bytes_drained", exp_bytes.size(), 0);
        if (r.chk[3]) chk("length", payload_length, r.len);
        if (r.chk[2]) chk("crc_err", crc_err, r.ce);
        if (r.chk[1]) chk("len_err", len_err, r.le);
        if (r.chk[0]) chk("ctrl_err", ctrl_err, r.ke);
      end
    end
  endtask

  task automatic step(input logic [63:0] d, input logic [7:0] c);
    rx_d = d;
    rx_c = c;
    @(posedge clk);
    #1;
    monitor();
  endtask

  function automatic logic [31:0] crc_calc(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, tx_b[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic build(input int n, input int pat, input int flip, input int kidx);
    logic [31:0] fcs;
    tx_b.delete();
    tx_k.delete();
    for (int i = 0; i < 6; i++) tx_b.push_back(DST[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) tx_b.push_back(SRC[47-8*i -: 8]);
    tx_b.push_back(ETYPE[15:8]);
    tx_b.push_back(ETYPE[7:0]);
    for (int i = 0; i < n; i++) tx_b.push_back((pat == 0) ? 8'h55 : 8'(i + pat));
    fcs = ~crc_calc(tx_b.size());
    for (int i = 0; i < 4; i++) tx_b.push_back(fcs[8*i +: 8]);
    for (int i = 0; i < tx_b.size(); i++) tx_k.push_back(1'b0);
    if (flip >= 0) tx_b[14+flip] = tx_b[14+flip] ^ 8'h01;
    if (kidx >= 0) begin
      tx_b[14+kidx] = 8'hFE;
      tx_k[14+kidx] = 1'b1;
    end
  endtask

  task automatic expect_frame(input int n, input int dc_idx, input res_t r);
    int ne;
    ne = (n > 1500) ? 1500 : n;
    exp_hdr.push_back({DST, SRC, ETYPE});
    for (int i = 0; i < ne; i++) exp_bytes.push_back({(i == dc_idx), tx_b[14+i]});
    exp_res.push_back(r);
  endtask

  task automatic send(input logic [63:0] start_w, input int gap, input int abort_w);
    int nb, nw, idx;
    logic [63:0] d;
    logic [7:0]  c;
    step(start_w, 8'h01);
    nb = tx_b.size();
    nw = nb / 8 + 1;
    for (int w = 0; w < nw; w++) begin
      for (int l = 0; l < 8; l++) begin
        idx = w * 8 + l;
        if (idx < nb) begin
          d[8*l +: 8] = tx_b[idx];
          c[l] = tx_k[idx];
        end else if (idx == nb) begin
          d[8*l +: 8] = 8'hFD;
          c[l] = 1'b1;
        end else begin
          d[8*l +: 8] = 8'h07;
          c[l] = 1'b1;
        end
      end
      if (w == abort_w) begin
        rst_n = 1'b0;
        step(d, c);
        rst_n = 1'b1;
        chk("reset_mid_frame_outputs", all_outputs(), '0);
        exp_bytes.delete();
        exp_hdr.delete();
        exp_res.delete();
        break;
      end
      step(d, c);
    end
    repeat (gap) step(IDLE_W, 8'hFF);
  endtask

  initial begin
    int hb, db;
    rst_n = 1'b0;
    rx_d  = IDLE_W;
    rx_c  = 8'hFF;
    repeat (3) step(IDLE_W, 8'hFF);
    chk("reset_outputs", all_outputs(), '0);
    rst_n = 1'b1;
    repeat (2) step(IDLE_W, 8'hFF);

    // Good frame
    build(46, 0, -1, -1);
    expect_frame(46, -1, '{len: 16'd46, ce: 1'b0, le: 1'b0, ke: 1'b0, chk: 4'hF});
    send(START_W, 2, -1);

    // Terminate lane sweep, back-to-back with one idle word
    for (int n = 46; n <= 53; n++) begin
      build(n, n, -1, -1);
      expect_frame(n, -1, '{len: 16'(n), ce: 1'b0, le: 1'b0, ke: 1'b0, chk: 4'hF});
      send(START_W, 1, -1);
    end

    // Corrupted payload byte 10
    build(46, 0, 10, -1);
    expect_frame(46, -1, '{len: 16'd46, ce: 1'b1, le: 1'b0, ke: 1'b0, chk: 4'hF});
    send(START_W, 2, -1);

    // Error control character mid-payload
    build(46, 3, -1, 20);
    expect_frame(46, 20, '{len: 16'd0, ce: 1'b0, le: 1'b0, ke: 1'b1, chk: 4'h1});
    send(START_W, 2, -1);

    // Bad preamble: frame must be ignored
    hb = hdr_seen;
    db = done_seen;
    build(46, 0, -1, -1);
    send(BADST_W, 2, -1);
    chk("badstart_no_hdr", hdr_seen, hb);
    chk("badstart_no_done", done_seen, db);

    // Oversize then a clean frame
    build(1501, 7, -1, -1);
    expect_frame(1501, -1, '{len: 16'd1500, ce: 1'b0, le: 1'b1, ke: 1'b0, chk: 4'hA});
    send(START_W, 2, -1);
    build(50, 9, -1, -1);
    expect_frame(50, -1, '{len: 16'd50, ce: 1'b0, le: 1'b0, ke: 1'b0, chk: 4'hF});
    send(START_W, 2, -1);

    // Reset during payload byte 20, then a clean frame
    db = done_seen;
    build(46, 0, -1, -1);
    expect_frame(46, -1, '{len: 16'd46, ce: 1'b0, le: 1'b0, ke: 1'b0, chk: 4'hF});
    send(START_W, 3, 4);
    chk("reset_no_done", done_seen, db);
    build(47, 5, -1, -1);
    expect_frame(47, -1, '{len: 16'd47, ce: 1'b0, le: 1'b0, ke: 1'b0, chk: 4'hF});
    send(START_W, 3, -1);

    chk("results_drained", exp_res.size(), 0);
    chk("headers_drained", exp_hdr.size(), 0);
    chk("final_bytes_drained", exp_bytes.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
